// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer for the instruction-memory port.
// Owns the program counter and issues sequential fetches (PC+4). Holds its
// output while IF/ID is stalled and applies branch/jump redirects. A redirect
// that lands while a fetch is outstanding lets that fetch finish and drops it.
// The registered output (valid/pc/inst) feeds the IF/ID latch directly.
//
// Optional build macro: FETCH_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target pulses misalign_o, latches
//               bad_addr_o and parks the fetcher until reset.
//   undefined : misalign_o/bad_addr_o do not exist; the redirect target's
//               low two bits are forced to zero.
module pc_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_ce_o,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  output logic                  if_valid_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [INST_WIDTH-1:0] if_inst_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] bad_addr_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_KILL} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   kill_addr_q, kill_addr_d;
  logic                    ce_q;
  logic                    vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   ifpc_q, ifpc_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;

  logic                    req;
  logic                    ack_ok;
  logic                    redir;
  logic [ADDR_WIDTH-1:0]   tgt;
  logic                    halt_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic                    halt_d;
  logic                    mis_q, mis_d;
  logic [ADDR_WIDTH-1:0]   bad_q, bad_d;
  logic                    mis_hit;

  // Target is taken as-is; misalignment is detected rather than masked.
  assign tgt     = redirect_pc_i;
  assign mis_hit = redir && (redirect_pc_i[1:0] != 2'b00);
`else
  // Without the check a misaligned target is silently word-aligned.
  assign tgt     = redirect_pc_i & ~ADDR_WIDTH'(3);
  assign halt_q  = 1'b0;
`endif

  // Once parked by a misaligned redirect, further redirects are ignored.
  assign redir = redirect_i && !halt_q;

  // Request strobe: REQ fetches only when the output slot can take the data;
  // KILL keeps the abandoned request up until memory acknowledges it.
  always_comb begin
    req = 1'b0;
    case (state_q)
      S_REQ:   req = !halt_q && !(vld_q && stall_i);
      S_KILL:  req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  assign ack_ok      = req && imem_ack_i;
  assign imem_req_o  = req;
  assign imem_addr_o = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign imem_ce_o   = ce_q;
  assign if_valid_o  = vld_q;
  assign if_pc_o     = ifpc_q;
  assign if_inst_o   = inst_q;

  // Next-state and datapath: normal sequencing first, redirect overrides last.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    vld_d       = vld_q;
    ifpc_d      = ifpc_q;
    inst_d      = inst_q;
`ifdef FETCH_ALIGN_CHECK_EN
    halt_d      = halt_q;
    mis_d       = 1'b0;
    bad_d       = bad_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (ack_ok) begin
          vld_d  = 1'b1;
          ifpc_d = pc_q;
          inst_d = imem_rdata_i;
          pc_d   = pc_q + ADDR_WIDTH'(4);
        end else if (vld_q && stall_i) begin
          state_d = S_HOLD;
        end else begin
          // Either nothing was held or IF/ID just took it.
          vld_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          state_d = S_REQ;
          vld_d   = 1'b0;
        end
      end
      S_KILL: begin
        // Stale data is dropped; fetch restarts at the redirect target.
        if (ack_ok) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redir) begin
      vld_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (mis_hit) begin
        halt_d = 1'b1;
        mis_d  = 1'b1;
        bad_d  = redirect_pc_i;
      end else begin
        pc_d = tgt;
      end
`else
      pc_d = tgt;
`endif
      case (state_q)
        S_REQ: begin
          if (req && !imem_ack_i) begin
            state_d     = S_KILL;
            kill_addr_d = pc_q;
          end else begin
            state_d = S_REQ;
          end
        end
        S_KILL:  state_d = imem_ack_i ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end
  end

  // State, PC and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      vld_q       <= 1'b0;
      ifpc_q      <= '0;
      inst_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      vld_q       <= vld_d;
      ifpc_q      <= ifpc_d;
      inst_q      <= inst_d;
    end
  end

  // Chip enable comes up in the first cycle out of reset and stays up.
  always_ff @(posedge clk) begin
    if (rst)                    ce_q <= 1'b0;
    else if (state_q == S_IDLE) ce_q <= 1'b1;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Misalignment trap: one-cycle pulse, sticky bad address and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
      mis_q  <= 1'b0;
      bad_q  <= '0;
    end else begin
      halt_q <= halt_d;
      mis_q  <= mis_d;
      bad_q  <= bad_d;
    end
  end

  assign misalign_o = mis_q;
  assign bad_addr_o = bad_q;
`endif

endmodule
